// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register index width,
// FSM state codes and small helpers used by the controller and its interface.
package pipe_ctrl_pkg;

   localparam int REG_IDX_W = 5;

   localparam logic [1:0] ST_RUN = 2'd0;
   localparam logic [1:0] ST_MUL = 2'd1;
   localparam logic [1:0] ST_MEM = 2'd2;

   function automatic int mul_cnt_width(input int lat);
      return $clog2(lat);
   endfunction

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   function automatic logic is_load_use(input logic                 memread,
                                        input logic [REG_IDX_W-1:0] rd,
                                        input logic [REG_IDX_W-1:0] rs1,
                                        input logic [REG_IDX_W-1:0] rs2);
      return memread && (rd != '0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave):
// hazard sources flow in, stall/flush controls and performance counters flow out.
interface pipe_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
);

   logic [REG_IDX_W-1:0] id_rs1_i;
   logic [REG_IDX_W-1:0] id_rs2_i;
   logic [REG_IDX_W-1:0] ex_rd_i;
   logic                 ex_memread_i;
   logic                 ex_mul_start_i;
   logic                 id_branch_taken_i;
   logic                 mem_req_i;
   logic                 mem_ack_i;

   logic                 pc_write_o;
   logic                 ifid_stall_o;
   logic                 ifid_flush_o;
   logic                 idex_nop_o;
   logic                 pipe_stall_o;
   logic [CNT_W-1:0]     stall_cnt_o;
   logic [CNT_W-1:0]     flush_cnt_o;

   modport master (
      output id_rs1_i, id_rs2_i, ex_rd_i, ex_memread_i, ex_mul_start_i,
             id_branch_taken_i, mem_req_i, mem_ack_i,
      input  pc_write_o, ifid_stall_o, ifid_flush_o, idex_nop_o, pipe_stall_o,
             stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  id_rs1_i, id_rs2_i, ex_rd_i, ex_memread_i, ex_mul_start_i,
             id_branch_taken_i, mem_req_i, mem_ack_i,
      output pc_write_o, ifid_stall_o, ifid_flush_o, idex_nop_o, pipe_stall_o,
             stall_cnt_o, flush_cnt_o
   );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Enable-driven up counter that sticks at all-ones instead of wrapping,
// so long-running performance statistics never roll back to small values.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count <= '0;
      end else if (inc_en && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use and taken-branch
// handling in ID, plus a small FSM freezing the pipe for multi-cycle MUL and data-port waits.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 2,
   parameter int CNT_W   = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   pipe_hazard_ctrl_if.slave  bus
);

   localparam int              MC_W     = mul_cnt_width(MUL_LAT);
   localparam logic [MC_W-1:0] MUL_LOAD = MC_W'(MUL_LAT - 2);

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [MC_W-1:0] mul_cnt;
   logic [MC_W-1:0] mul_cnt_nxt;
   logic            freeze;
   logic            load_use;
   logic            pc_write;
   logic            ifid_stall;
   logic            ifid_flush;
   logic            idex_nop;
   logic            stall_inc;
   logic            flush_inc;

   assign load_use = is_load_use(bus.ex_memread_i, bus.ex_rd_i, bus.id_rs1_i, bus.id_rs2_i);

   // A data-port wait outranks a MUL starting in the same cycle; a MUL arriving
   // with the ack is picked up directly so the pipe never unfreezes in between
   always_comb begin
      state_nxt   = state;
      mul_cnt_nxt = mul_cnt;
      freeze      = 1'b0;
      case (state)
         ST_RUN: begin
            if (bus.mem_req_i && !bus.mem_ack_i) begin
               freeze    = 1'b1;
               state_nxt = ST_MEM;
            end else if (bus.ex_mul_start_i) begin
               freeze      = 1'b1;
               mul_cnt_nxt = MUL_LOAD;
               state_nxt   = ST_MUL;
            end
         end
         ST_MUL: begin
            if (mul_cnt != '0) begin
               freeze      = 1'b1;
               mul_cnt_nxt = mul_cnt - 1'b1;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_MEM: begin
            if (!bus.mem_ack_i) begin
               freeze = 1'b1;
            end else if (bus.ex_mul_start_i) begin
               freeze      = 1'b1;
               mul_cnt_nxt = MUL_LOAD;
               state_nxt   = ST_MUL;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ST_RUN;
         mul_cnt <= '0;
      end else begin
         state   <= state_nxt;
         mul_cnt <= mul_cnt_nxt;
      end
   end

   // A freeze defers any taken branch; ID simply re-evaluates it after release
   always_comb begin
      pc_write   = 1'b1;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_nop   = 1'b0;
      if (rst_i) begin
         pc_write   = 1'b0;
         ifid_flush = 1'b1;
      end else if (freeze) begin
         pc_write   = 1'b0;
         ifid_stall = 1'b1;
      end else if (load_use) begin
         pc_write   = 1'b0;
         ifid_stall = 1'b1;
         idex_nop   = 1'b1;
      end else if (bus.id_branch_taken_i) begin
         ifid_flush = 1'b1;
      end
   end

   assign bus.pc_write_o   = pc_write;
   assign bus.ifid_stall_o = ifid_stall;
   assign bus.ifid_flush_o = ifid_flush;
   assign bus.idex_nop_o   = idex_nop;
   assign bus.pipe_stall_o = freeze && !rst_i;

   assign stall_inc = !rst_i && (freeze || load_use);
   assign flush_inc = !rst_i && ifid_flush;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_en (stall_inc),
      .count  (bus.stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_en (flush_inc),
      .count  (bus.flush_cnt_o)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (MUL_LAT 4/2/4, CNT_W 32/32/4) share one
// stimulus stream; a cycle-level behavioural model checks all of them every cycle.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs1 = '0;
   logic [4:0] id_rs2 = '0;
   logic [4:0] ex_rd = '0;
   logic       ex_memread = 1'b0;
   logic       mul_start = 1'b0;
   logic       br_taken = 1'b0;
   logic       mem_req = 1'b0;
   logic       mem_ack = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(32)) bus_a ();
   pipe_hazard_ctrl_if #(.CNT_W(32)) bus_b ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  bus_c ();

   assign bus_a.id_rs1_i = id_rs1;   assign bus_b.id_rs1_i = id_rs1;   assign bus_c.id_rs1_i = id_rs1;
   assign bus_a.id_rs2_i = id_rs2;   assign bus_b.id_rs2_i = id_rs2;   assign bus_c.id_rs2_i = id_rs2;
   assign bus_a.ex_rd_i = ex_rd;     assign bus_b.ex_rd_i = ex_rd;     assign bus_c.ex_rd_i = ex_rd;
   assign bus_a.ex_memread_i = ex_memread;
   assign bus_b.ex_memread_i = ex_memread;
   assign bus_c.ex_memread_i = ex_memread;
   assign bus_a.ex_mul_start_i = mul_start;
   assign bus_b.ex_mul_start_i = mul_start;
   assign bus_c.ex_mul_start_i = mul_start;
   assign bus_a.id_branch_taken_i = br_taken;
   assign bus_b.id_branch_taken_i = br_taken;
   assign bus_c.id_branch_taken_i = br_taken;
   assign bus_a.mem_req_i = mem_req; assign bus_b.mem_req_i = mem_req; assign bus_c.mem_req_i = mem_req;
   assign bus_a.mem_ack_i = mem_ack; assign bus_b.mem_ack_i = mem_ack; assign bus_c.mem_ack_i = mem_ack;

   pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(32)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
   pipe_hazard_ctrl #(.MUL_LAT(2), .CNT_W(32)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));
   pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4))  dut_c (.clk_i(clk), .rst_i(rst), .bus(bus_c));

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Control outputs packed as {pc_write, ifid_stall, ifid_flush, idex_nop, pipe_stall}
   function automatic logic [4:0] actual_ctl(input int i);
      case (i)
         0:       return {bus_a.pc_write_o, bus_a.ifid_stall_o, bus_a.ifid_flush_o, bus_a.idex_nop_o, bus_a.pipe_stall_o};
         1:       return {bus_b.pc_write_o, bus_b.ifid_stall_o, bus_b.ifid_flush_o, bus_b.idex_nop_o, bus_b.pipe_stall_o};
         default: return {bus_c.pc_write_o, bus_c.ifid_stall_o, bus_c.ifid_flush_o, bus_c.idex_nop_o, bus_c.pipe_stall_o};
      endcase
   endfunction

   function automatic longint actual_cnt(input int i, input bit flush);
      case (i)
         0:       return flush ? longint'(bus_a.flush_cnt_o) : longint'(bus_a.stall_cnt_o);
         1:       return flush ? longint'(bus_b.flush_cnt_o) : longint'(bus_b.stall_cnt_o);
         default: return flush ? longint'({28'd0, bus_c.flush_cnt_o}) : longint'({28'd0, bus_c.stall_cnt_o});
      endcase
   endfunction

   // Model: per instance, how many MUL cycles remain (freeze cycles plus the release
   // cycle), whether a data-port wait is open, and unbounded event counts
   int     lat[3]      = '{4, 2, 4};
   longint sat_max[3]  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
   int     mul_left[3] = '{0, 0, 0};
   int     nxt_mul[3]  = '{0, 0, 0};
   bit     mem_wait[3] = '{0, 0, 0};
   bit     nxt_mem[3]  = '{0, 0, 0};
   longint stall_n[3]  = '{0, 0, 0};
   longint flush_n[3]  = '{0, 0, 0};
   longint nxt_stall[3] = '{0, 0, 0};
   longint nxt_flush[3] = '{0, 0, 0};

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         bit         frz;
         bit         lu;
         logic [4:0] exp_ctl;
         lu = ex_memread && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
         nxt_mul[i] = mul_left[i];
         nxt_mem[i] = mem_wait[i];
         frz = 1'b0;
         if (mul_left[i] > 0) begin
            frz = (mul_left[i] > 1);
            nxt_mul[i] = mul_left[i] - 1;
         end else if (mem_wait[i]) begin
            if (!mem_ack) frz = 1'b1;
            else begin
               nxt_mem[i] = 1'b0;
               if (mul_start) begin frz = 1'b1; nxt_mul[i] = lat[i] - 1; end
            end
         end else if (mem_req && !mem_ack) begin
            frz = 1'b1; nxt_mem[i] = 1'b1;
         end else if (mul_start) begin
            frz = 1'b1; nxt_mul[i] = lat[i] - 1;
         end
         if (rst)           exp_ctl = 5'b00100;
         else if (frz)      exp_ctl = 5'b01001;
         else if (lu)       exp_ctl = 5'b01010;
         else if (br_taken) exp_ctl = 5'b10100;
         else               exp_ctl = 5'b10000;
         checkOutput($sformatf("ctl[%0d]", i), actual_ctl(i), exp_ctl);
         checkOutput($sformatf("stall_cnt[%0d]", i), actual_cnt(i, 0),
                     (stall_n[i] > sat_max[i]) ? sat_max[i] : stall_n[i]);
         checkOutput($sformatf("flush_cnt[%0d]", i), actual_cnt(i, 1),
                     (flush_n[i] > sat_max[i]) ? sat_max[i] : flush_n[i]);
         nxt_stall[i] = stall_n[i] + ((!rst && (frz || lu)) ? 1 : 0);
         nxt_flush[i] = flush_n[i] + ((!rst && exp_ctl[2]) ? 1 : 0);
      end
   end

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            mul_left[i] = 0; mem_wait[i] = 1'b0; stall_n[i] = 0; flush_n[i] = 0;
         end else begin
            mul_left[i] = nxt_mul[i]; mem_wait[i] = nxt_mem[i];
            stall_n[i] = nxt_stall[i]; flush_n[i] = nxt_flush[i];
         end
      end
   end

   task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic memread, input logic mul, input logic taken,
                                input logic req, input logic ack);
      @(posedge clk);
      #1;
      id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_memread = memread;
      mul_start = mul; br_taken = taken; mem_req = req; mem_ack = ack;
   endtask

   task automatic settle;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #2;
      checkOutput("reset pc_write", bus_a.pc_write_o, 0);
      checkOutput("reset ifid_flush", bus_a.ifid_flush_o, 1);
      checkOutput("reset pipe_stall", bus_a.pipe_stall_o, 0);
      checkOutput("reset stall_cnt", bus_a.stall_cnt_o, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      applyStimulus(0, 5, 5, 1, 0, 0, 0, 0); settle;
      checkOutput("load-use pc_write", bus_a.pc_write_o, 0);
      checkOutput("load-use ifid_stall", bus_a.ifid_stall_o, 1);
      checkOutput("load-use idex_nop", bus_a.idex_nop_o, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); settle;
      checkOutput("load-use stall_cnt", bus_a.stall_cnt_o, 1);

      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0); settle;
      checkOutput("rd=x0 pc_write", bus_a.pc_write_o, 1);
      checkOutput("rd=x0 ifid_stall", bus_a.ifid_stall_o, 0);

      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0); settle;
      checkOutput("branch ifid_flush", bus_a.ifid_flush_o, 1);
      checkOutput("branch pc_write", bus_a.pc_write_o, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); settle;
      checkOutput("branch flush_cnt", bus_a.flush_cnt_o, 1);

      applyStimulus(5, 0, 5, 1, 0, 1, 0, 0); settle;
      checkOutput("branch+lu ifid_flush", bus_a.ifid_flush_o, 0);
      checkOutput("branch+lu idex_nop", bus_a.idex_nop_o, 1);

      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 0, 0); settle;
         checkOutput($sformatf("mul4 pipe_stall c%0d", k), bus_a.pipe_stall_o, (k < 3) ? 1 : 0);
         if (k == 3) checkOutput("mul4 release pc_write", bus_a.pc_write_o, 1);
         if (k < 2) checkOutput($sformatf("mul2 pipe_stall c%0d", k), bus_b.pipe_stall_o, (k == 0) ? 1 : 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); settle;
      checkOutput("mul4 stall_cnt", bus_a.stall_cnt_o, 5);
      checkOutput("mul2 stall_cnt", bus_b.stall_cnt_o, 4);

      for (int m = 0; m < 4; m++) begin
         applyStimulus(0, 0, 0, 0, 0, (m >= 1), 1, (m == 3)); settle;
         checkOutput($sformatf("mem pipe_stall c%0d", m), bus_a.pipe_stall_o, (m < 3) ? 1 : 0);
         checkOutput($sformatf("mem ifid_flush c%0d", m), bus_a.ifid_flush_o, (m == 3) ? 1 : 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); settle;
      checkOutput("mem stall_cnt", bus_a.stall_cnt_o, 8);
      checkOutput("mem flush_cnt", bus_a.flush_cnt_o, 2);

      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0); settle;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("mid-mul pipe_stall", bus_a.pipe_stall_o, 1);
      #1 rst = 1'b1;
      #1;
      checkOutput("async rst pipe_stall", bus_a.pipe_stall_o, 0);
      checkOutput("async rst ifid_flush", bus_a.ifid_flush_o, 1);
      checkOutput("async rst stall_cnt", bus_a.stall_cnt_o, 0);
      checkOutput("async rst flush_cnt", bus_a.flush_cnt_o, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      settle;
      checkOutput("post-rst pipe_stall", bus_a.pipe_stall_o, 0);
      checkOutput("post-rst pc_write", bus_a.pc_write_o, 1);

      for (int s = 0; s < 20; s++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1); settle;
      checkOutput("sat wide stall_cnt", bus_a.stall_cnt_o, 20);
      checkOutput("sat narrow stall_cnt", bus_c.stall_cnt_o, 15);
      checkOutput("sat ack pipe_stall", bus_c.pipe_stall_o, 0);

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); settle;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); settle;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
